// File: rtl/dalu_seq.sv
// Sequential ALU with single-cycle ops, iterative shifts and optional shift-add MUL.
// Define DALU_SEQ_MUL_EN to build the multiplier; otherwise opcode 9 decodes as unknown.
module dalu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_SHLN = 4'd10;
  localparam logic [3:0] OP_SHRN = 4'd11;
  localparam logic [SHW:0] CNT_ONE = 1;

  state_t           state;
  logic [WIDTH-1:0] sh_r;
  logic             dir_r;
  logic [SHW:0]     cnt;

  logic [SHW-1:0]   n;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;
  logic             sc_multi;
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_c;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c;

`ifdef DALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd9;
  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   mpl_r;
  logic               mul_r;
  assign prod_nxt = prod_r + (mpl_r[0] ? mcand_r : '0);
`endif

  assign in_ready = (state == IDLE);
  assign n        = b[SHW-1:0];

  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    dif      = {1'b0, a} - {1'b0, b};
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_multi = 1'b0;
    case (op)
      OP_PASS: sc_res = b;
      OP_OR:   sc_res = a | b;
      OP_AND:  sc_res = a & b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOT:  sc_res = ~a;
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                 (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif[WIDTH-1:0];
        sc_c   = dif[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                 (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        sc_res = a << 1;
        sc_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        sc_res = a >> 1;
        sc_c   = a[0];
      end
      OP_SHLN, OP_SHRN: begin
        sc_res   = a;
        sc_multi = (n != '0);
      end
`ifdef DALU_SEQ_MUL_EN
      OP_MUL:  sc_multi = 1'b1;
`endif
      default: sc_res = '0;
    endcase
  end

  assign sh_nxt = dir_r ? (sh_r >> 1) : (sh_r << 1);
  assign sh_c   = dir_r ? sh_r[0] : sh_r[WIDTH-1];

  // Value committed on the final EXEC cycle, including that cycle's step
  always_comb begin
    fin_res = sh_nxt;
    fin_c   = sh_c;
`ifdef DALU_SEQ_MUL_EN
    if (mul_r) begin
      fin_res = prod_nxt[WIDTH-1:0];
      fin_c   = |prod_nxt[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (sc_multi) begin
              state <= EXEC;
              busy  <= 1'b1;
              sh_r  <= a;
              dir_r <= (op == OP_SHRN);
              cnt   <= {1'b0, n};
`ifdef DALU_SEQ_MUL_EN
              mul_r   <= (op == OP_MUL);
              mcand_r <= {{WIDTH{1'b0}}, a};
              mpl_r   <= b;
              prod_r  <= '0;
              if (op == OP_MUL)
                cnt <= (SHW+1)'(WIDTH);
`endif
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= sc_res;
              flags     <= {sc_v, sc_res[WIDTH-1],
                            sc_c, sc_res == '0};
            end
          end
        end
        EXEC: begin
          cnt  <= cnt - CNT_ONE;
          sh_r <= sh_nxt;
`ifdef DALU_SEQ_MUL_EN
          prod_r  <= prod_nxt;
          mcand_r <= mcand_r << 1;
          mpl_r   <= mpl_r >> 1;
`endif
          if (cnt == CNT_ONE) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= fin_res;
            flags     <= {1'b0, fin_res[WIDTH-1],
                          fin_c, fin_res == '0};
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dalu_seq.sv
// Bench for dalu_seq (WIDTH=16): directed vectors, literal expectations,
// and an arithmetic reference model compared on every valid output cycle.
module tb_dalu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic        armed = 1'b0;
  logic [15:0] m_res;
  logic [3:0]  m_flags;

  dalu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: flags packed as {V,S,C,Z}
  function automatic logic [19:0] model(input logic [3:0] o,
                                        input logic [15:0] x,
                                        input logic [15:0] y);
    logic [15:0] r;
    logic        c;
    logic        v;
    int          sx;
    int          sy;
    int          sr;
    int          nn;
    longint      p;
    r  = 16'h0;
    c  = 1'b0;
    v  = 1'b0;
    sx = int'($signed(x));
    sy = int'($signed(y));
    nn = int'(y[3:0]);
    case (o)
      4'd0: r = y;
      4'd1: r = x | y;
      4'd2: r = x & y;
      4'd3: r = x ^ y;
      4'd4: r = ~x;
      4'd5: begin
        p  = longint'(x) + longint'(y);
        r  = p[15:0];
        c  = (p > 65535);
        sr = sx + sy;
        v  = (sr > 32767) || (sr < -32768);
      end
      4'd6: begin
        r  = x - y;
        c  = (x < y);
        sr = sx - sy;
        v  = (sr > 32767) || (sr < -32768);
      end
      4'd7: begin r = x << 1; c = x[15]; end
      4'd8: begin r = x >> 1; c = x[0]; end
`ifdef DALU_SEQ_MUL_EN
      4'd9: begin
        p = longint'(x) * longint'(y);
        r = p[15:0];
        c = ((p >> 16) != 0);
      end
`endif
      4'd10: begin
        r = x << nn;
        c = (nn > 0) ? x[16-nn] : 1'b0;
      end
      4'd11: begin
        r = x >> nn;
        c = (nn > 0) ? x[nn-1] : 1'b0;
      end
      default: r = 16'h0;
    endcase
    return {v, r[15], c, (r == 16'h0), r};
  endfunction

  function automatic int model_lat(input logic [3:0] o,
                                   input logic [15:0] y);
`ifdef DALU_SEQ_MUL_EN
    if (o == 4'd9) return 17;
`endif
    if ((o == 4'd10 || o == 4'd11) && y[3:0] != 0)
      return int'(y[3:0]) + 1;
    return 1;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("armed_when_valid", {31'd0, armed}, 32'd1);
      if (armed) begin
        chk("model_result", {16'd0, result}, {16'd0, m_res});
        chk("model_flags", {28'd0, flags}, {28'd0, m_flags});
        chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
      end
    end
  end

  task automatic accept(input logic [3:0] o,
                        input logic [15:0] x,
                        input logic [15:0] y);
    logic [19:0] m;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    m        = model(o, x, y);
    m_res    = m[15:0];
    m_flags  = m[19:16];
    armed    = 1'b1;
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ~x;
    b        = ~y;
    op       = ~o;
  endtask

  task automatic run(input string nm,
                     input logic [3:0] o,
                     input logic [15:0] x,
                     input logic [15:0] y,
                     input logic [15:0] er,
                     input logic [3:0] ef,
                     input int elat,
                     input int hold);
    int lat;
    accept(o, x, y);
    chk({nm, "_busy"}, {31'd0, busy}, (elat > 1) ? 32'd1 : 32'd0);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_model_lat"}, lat, model_lat(o, y));
    chk({nm, "_result"}, {16'd0, result}, {16'd0, er});
    chk({nm, "_flags"}, {28'd0, flags}, {28'd0, ef});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op       = 4'd5;
      a        = 16'h0001;
      b        = 16'h0001;
      @(posedge clk);
      #1;
      chk({nm, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
      chk({nm, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({nm, "_hold_res"}, {16'd0, result}, {16'd0, er});
      chk({nm, "_hold_flags"}, {28'd0, flags}, {28'd0, ef});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    armed     = 1'b0;
    chk({nm, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({nm, "_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    op        = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    run("add_ovf",  4'd5,  16'h7FFF, 16'h0001, 16'h8000, 4'b1100, 1, 0);
    run("add_cry",  4'd5,  16'hFFFF, 16'h0001, 16'h0000, 4'b0011, 1, 0);
    run("sub_brw",  4'd6,  16'h0002, 16'h0003, 16'hFFFF, 4'b0110, 1, 0);
    run("sub_ovf",  4'd6,  16'h8000, 16'h0001, 16'h7FFF, 4'b1000, 1, 0);
    run("pass",     4'd0,  16'h1111, 16'hABCD, 16'hABCD, 4'b0100, 1, 0);
    run("or",       4'd1,  16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000, 1, 0);
    run("and",      4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1, 0);
    run("xor",      4'd3,  16'hFFFF, 16'hFFFF, 16'h0000, 4'b0001, 1, 0);
    run("not",      4'd4,  16'h0000, 16'h1234, 16'hFFFF, 4'b0100, 1, 0);
    run("shl",      4'd7,  16'h8000, 16'h0000, 16'h0000, 4'b0011, 1, 0);
    run("shr",      4'd8,  16'h0001, 16'h0000, 16'h0000, 4'b0011, 1, 0);
    run("unk",      4'd13, 16'h0005, 16'h0005, 16'h0000, 4'b0001, 1, 0);
    run("shrn4",    4'd11, 16'h8001, 16'h0004, 16'h0800, 4'b0000, 5, 0);
    run("shln1",    4'd10, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 2, 0);
    run("shln0",    4'd10, 16'h1234, 16'h0010, 16'h1234, 4'b0000, 1, 0);
    run("shrn15",   4'd11, 16'hFFFF, 16'h000F, 16'h0001, 4'b0010, 16, 0);
`ifdef DALU_SEQ_MUL_EN
    run("mul_hi",   4'd9,  16'h0100, 16'h0100, 16'h0000, 4'b0011, 17, 0);
    run("mul_lo",   4'd9,  16'h00FF, 16'h0003, 16'h02FD, 4'b0000, 17, 0);
`else
    run("mul_off",  4'd9,  16'h0100, 16'h0100, 16'h0000, 4'b0001, 1, 0);
`endif
    run("hold",     4'd3,  16'h5A5A, 16'h0F0F, 16'h5555, 4'b0000, 1, 3);

    // Abort a multi-cycle op on its 5th EXEC cycle
`ifdef DALU_SEQ_MUL_EN
    accept(4'd9, 16'h1234, 16'h5678);
`else
    accept(4'd11, 16'hFFFF, 16'h000F);
`endif
    repeat (4) begin
      chk("abort_busy_exec", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    armed = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    chk("abort_flags", {28'd0, flags}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_quiet", {31'd0, out_valid}, 32'd0);
    run("add_after", 4'd5, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dalu_seq.md
DALU_SEQ -- requirements
Module: dalu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width; legal values are powers of 2 from 4 to 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-count width taken from b.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 op  input  4  opcode: 0 PASS, 1 OR, 2 AND, 3 XOR, 4 NOT, 5 ADD, 6 SUB, 7 SHL, 8 SHR, 9 MUL, 10 SHLN, 11 SHRN.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 flags  output  4  [0] Z, [1] C, [2] S, [3] V; all registered.
REQ-013 busy  output  1  high in EXEC.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC and DONE; in_ready SHALL equal (state==IDLE).
REQ-015 On accept (in_valid&&in_ready), a, b and op SHALL be captured; later input changes SHALL have no effect on that operation.
REQ-016 Ops 0-8, unknown ops 12-15, and SHLN/SHRN with count 0 SHALL go IDLE->DONE, with out_valid high the cycle after accept.
REQ-017 SHLN/SHRN SHALL shift a by n=b[SHW-1:0], one bit per EXEC cycle, logical (zero fill); out_valid SHALL rise n+1 cycles after accept.
REQ-018 MUL SHALL perform shift-add over WIDTH EXEC cycles; result = low WIDTH bits of unsigned a*b; out_valid SHALL rise WIDTH+1 cycles after accept.
REQ-019 In DONE, result and flags SHALL hold stable until out_valid&&out_ready, then the FSM SHALL return to IDLE; no accept SHALL occur in that same cycle.
REQ-020 Results: PASS=b; NOT=~a; OR/AND/XOR bitwise; ADD/SUB modulo 2^WIDTH; SHL/SHR by 1; unknown op =0.
REQ-021 Z SHALL equal (result==0); S SHALL equal result[WIDTH-1].
REQ-022 C: ADD carry-out; SUB borrow (a<b unsigned); SHL/SHR/SHLN/SHRN the last bit shifted out (0 if n=0); MUL 1 if the high half of the product is nonzero; otherwise 0.
REQ-023 V: ADD 1 when a and b have equal sign and result sign differs; SUB 1 when a and b signs differ and result sign differs from a; otherwise 0.

Reset
REQ-024 While rst_n=0 at a clock edge, the FSM SHALL enter IDLE, and result, flags, out_valid and busy SHALL be 0.
REQ-025 Reset in EXEC or DONE SHALL abort the operation with no out_valid pulse; in_ready SHALL be 1 in the first cycle after rst_n returns high.

Configuration
REQ-026 Macro DALU_SEQ_MUL_EN defined: MUL SHALL be implemented per REQ-018.
REQ-027 Macro DALU_SEQ_MUL_EN undefined: no multiplier logic SHALL exist, and opcode 9 SHALL behave as an unknown op (result 0, Z=1, C=S=V=0, single cycle).

Verification (WIDTH=16)
REQ-028 ADD a=0x7FFF, b=0x0001 -> result 0x8000, Z=0, C=0, S=1, V=1; out_valid 1 cycle after accept.
REQ-029 SUB a=0x0002, b=0x0003 -> 0xFFFF, C=1, S=1, V=0; SUB a=0x8000, b=0x0001 -> 0x7FFF, V=1.
REQ-030 SHRN a=0x8001, b=4 -> 0x0800, C=0, out_valid 5 cycles after accept; SHLN a=0x8001, b=1 -> 0x0002, C=1; SHLN with b=0 -> a unchanged, latency 1.
REQ-031 MUL 0x0100*0x0100 -> 0x0000, Z=1, C=1, latency 17; MUL 0x00FF*0x0003 -> 0x02FD, C=0; macro undefined -> 0x0000, Z=1, C=0, latency 1.
REQ-032 Hold out_ready=0 for 3 cycles after out_valid -> result and flags stable, in_ready=0, and in_valid pulses ignored; after out_ready=1 for one cycle, in_ready=1.
REQ-033 Assert rst_n=0 on the 5th EXEC cycle of MUL -> no out_valid pulse, busy=0, in_ready=1 after release; a following ADD 1+1 returns 0x0002.
